// File: rtl/branch_predict_ctrl_if.sv
// Fetch lookup, execute resolution and performance-counter signals between the
// pipeline (master) and the branch predictor (slave).
interface branch_predict_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      PCF;
  logic             Predict_branchF;
  logic [31:0]      PredTargetF;
  logic             BranchE;
  logic             TakenE;
  logic [31:0]      PCE;
  logic [31:0]      PCTargetE;
  logic             Predict_branchE;
  logic [31:0]      PredTargetE;
  logic             MispredictE;
  logic [31:0]      RedirectPCE;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] MispredCnt;

  modport master (
    output PCF, BranchE, TakenE, PCE, PCTargetE, Predict_branchE, PredTargetE,
    input  Predict_branchF, PredTargetF, MispredictE, RedirectPCE, FlushD, FlushE,
           BranchCnt, MispredCnt
  );

  modport slave (
    input  PCF, BranchE, TakenE, PCE, PCTargetE, Predict_branchE, PredTargetE,
    output Predict_branchF, PredTargetF, MispredictE, RedirectPCE, FlushD, FlushE,
           BranchCnt, MispredCnt
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch lookup,
// execute-stage training, mispredict redirect and branch/mispredict counters.
module branch_predict_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                rst,
  branch_predict_ctrl_if.slave bp
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]   tag_t;

  logic [ENTRIES-1:0] validQ;
  logic [1:0]         ctrQ    [ENTRIES];
  tag_t               tagQ    [ENTRIES];
  logic [31:0]        targetQ [ENTRIES];
  logic [CNT_W-1:0]   branchCntQ;
  logic [CNT_W-1:0]   mispredCntQ;

  idx_t        idxF, idxE;
  tag_t        tagF, tagE;
  logic        hitF, hitE;
  logic        mispredRaw;
  logic [31:0] pcPlus4E;
  logic [1:0]  unusedPcBits;

  assign idxF = bp.PCF[INDEX_BITS+1:2];
  assign tagF = bp.PCF[31:INDEX_BITS+2];
  assign idxE = bp.PCE[INDEX_BITS+1:2];
  assign tagE = bp.PCE[31:INDEX_BITS+2];
  assign unusedPcBits = bp.PCF[1:0] ^ bp.PCE[1:0];

  assign hitF = validQ[idxF] && (tagQ[idxF] == tagF);
  assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

  assign pcPlus4E   = bp.PCE + 32'd4;
  assign mispredRaw = bp.BranchE &&
                      ((bp.TakenE != bp.Predict_branchE) ||
                       (bp.TakenE && bp.Predict_branchE && (bp.PredTargetE != bp.PCTargetE)));

  function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  // All fetch/execute outputs are forced low while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bp.Predict_branchF = 1'b0;
    bp.PredTargetF     = '0;
    bp.MispredictE     = 1'b0;
    bp.RedirectPCE     = '0;
    if (!rst) begin
      bp.Predict_branchF = hitF && ctrQ[idxF][1];
      bp.PredTargetF     = hitF ? targetQ[idxF] : '0;
      bp.MispredictE     = mispredRaw;
      bp.RedirectPCE     = (bp.BranchE && bp.TakenE) ? bp.PCTargetE : pcPlus4E;
    end
  end

  assign bp.FlushD     = bp.MispredictE;
  assign bp.FlushE     = bp.MispredictE;
  assign bp.BranchCnt  = branchCntQ;
  assign bp.MispredCnt = mispredCntQ;

  // Control state: valid bits, counters and performance counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes the lookup see old contents.
    if (rst) begin
      validQ      <= '0;
      branchCntQ  <= '0;
      mispredCntQ <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrQ[i] <= 2'b01;
    end else if (bp.BranchE) begin
      if (hitE) begin
        ctrQ[idxE] <= ctrStep(ctrQ[idxE], bp.TakenE);
      end else if (bp.TakenE) begin
        validQ[idxE] <= 1'b1;
        ctrQ[idxE]   <= 2'b10;
      end
      if (branchCntQ != '1) branchCntQ <= branchCntQ + 1'b1;
      if (mispredRaw && (mispredCntQ != '1)) mispredCntQ <= mispredCntQ + 1'b1;
    end
  end

  // NOTE: tag/target storage is deliberately not reset; the cleared valid bit
  // masks whatever it holds, so the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && bp.BranchE && bp.TakenE) begin
      tagQ[idxE]    <= tagE;
      targetQ[idxE] <= bp.PCTargetE;
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: directed stimulus pushes expected
// observations, a negedge monitor pops and compares them.
module tb_branch_predict_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predict_ctrl_if #(.CNT_W(16)) bpIf ();

  branch_predict_ctrl #(.INDEX_BITS(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bp (bpIf)
  );

  typedef struct {
    string       name;
    logic        predF;
    logic [31:0] tgtF;
    logic        misp;
    logic        chkRedir;
    logic [31:0] redir;
    logic [15:0] bcnt;
    logic [15:0] mcnt;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the posedge; the monitor samples at negedge.
  task automatic drv(input logic r, input logic bE, input logic tE,
                     input logic [31:0] pce, input logic [31:0] pct,
                     input logic pb, input logic [31:0] pbt, input logic [31:0] pcf);
    @(posedge clk);
    #1;
    rst                  = r;
    bpIf.BranchE         = bE;
    bpIf.TakenE          = tE;
    bpIf.PCE             = pce;
    bpIf.PCTargetE       = pct;
    bpIf.Predict_branchE = pb;
    bpIf.PredTargetE     = pbt;
    bpIf.PCF             = pcf;
  endtask

  task automatic ex(input string n, input logic pf, input logic [31:0] tf, input logic m,
                    input logic cr, input logic [31:0] rd, input logic [15:0] bc,
                    input logic [15:0] mc);
    exp_t e;
    e.name = n; e.predF = pf; e.tgtF = tf; e.misp = m;
    e.chkRedir = cr; e.redir = rd; e.bcnt = bc; e.mcnt = mc;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check({e.name, ".predF"},  {31'd0, bpIf.Predict_branchF}, {31'd0, e.predF});
      check({e.name, ".tgtF"},   bpIf.PredTargetF,              e.tgtF);
      check({e.name, ".misp"},   {31'd0, bpIf.MispredictE},     {31'd0, e.misp});
      check({e.name, ".flushD"}, {31'd0, bpIf.FlushD},          {31'd0, e.misp});
      check({e.name, ".flushE"}, {31'd0, bpIf.FlushE},          {31'd0, e.misp});
      if (e.chkRedir) check({e.name, ".redir"}, bpIf.RedirectPCE, e.redir);
      check({e.name, ".bcnt"},   {16'd0, bpIf.BranchCnt},       {16'd0, e.bcnt});
      check({e.name, ".mcnt"},   {16'd0, bpIf.MispredCnt},      {16'd0, e.mcnt});
    end
  end

  initial begin
    int waitCycles;
    rst = 1'b1;
    bpIf.BranchE = 1'b0; bpIf.TakenE = 1'b0; bpIf.PCE = '0; bpIf.PCTargetE = '0;
    bpIf.Predict_branchE = 1'b0; bpIf.PredTargetE = '0; bpIf.PCF = 32'h40;

    // Reset held with a live branch: outputs must stay low.
    drv(1, 1, 1, 32'h40, 32'h100, 0, 32'h0, 32'h40);
    ex("rst_outputs", 0, 32'h0, 0, 1, 32'h0, 16'd0, 16'd0);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h40);
    ex("after_reset", 0, 32'h0, 0, 0, 32'h0, 16'd0, 16'd0);

    // First taken branch allocates; lookup in the same cycle still misses.
    drv(0, 1, 1, 32'h40, 32'h100, 0, 32'h0, 32'h40);
    ex("alloc_taken", 0, 32'h0, 1, 1, 32'h100, 16'd0, 16'd0);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h40);
    ex("alloc_visible", 1, 32'h100, 0, 0, 32'h0, 16'd1, 16'd1);

    // Correctly predicted taken branches drive the counter to strong taken.
    drv(0, 1, 1, 32'h40, 32'h100, 1, 32'h100, 32'h40);
    ex("taken_hit1", 1, 32'h100, 0, 1, 32'h100, 16'd1, 16'd1);
    drv(0, 1, 1, 32'h40, 32'h100, 1, 32'h100, 32'h40);
    ex("taken_hit2", 1, 32'h100, 0, 1, 32'h100, 16'd2, 16'd1);
    drv(0, 1, 1, 32'h40, 32'h100, 1, 32'h100, 32'h40);
    ex("taken_hit3", 1, 32'h100, 0, 1, 32'h100, 16'd3, 16'd1);

    // Two not-taken outcomes: 11 -> 10 (still predicts) -> 01 (stops predicting).
    drv(0, 1, 0, 32'h40, 32'h100, 1, 32'h100, 32'h40);
    ex("nt_first", 1, 32'h100, 1, 1, 32'h44, 16'd4, 16'd1);
    drv(0, 1, 0, 32'h40, 32'h100, 1, 32'h100, 32'h40);
    ex("nt_second", 1, 32'h100, 1, 1, 32'h44, 16'd5, 16'd2);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h40);
    ex("weak_nt_hit", 0, 32'h100, 0, 0, 32'h0, 16'd6, 16'd3);

    // Alias at the same index replaces the entry.
    drv(0, 1, 1, 32'h80, 32'h200, 0, 32'h0, 32'h40);
    ex("alias_alloc", 0, 32'h100, 1, 1, 32'h200, 16'd6, 16'd3);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h40);
    ex("alias_old_miss", 0, 32'h0, 0, 0, 32'h0, 16'd7, 16'd4);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h80);
    ex("alias_new_hit", 1, 32'h200, 0, 0, 32'h0, 16'd7, 16'd4);

    // Not-taken miss does not allocate or disturb the resident entry.
    drv(0, 1, 0, 32'hC0, 32'h500, 0, 32'h0, 32'h80);
    ex("nt_miss", 1, 32'h200, 0, 1, 32'hC4, 16'd7, 16'd4);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h80);
    ex("nt_miss_keep", 1, 32'h200, 0, 0, 32'h0, 16'd8, 16'd4);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'hC0);
    ex("nt_miss_noalloc", 0, 32'h0, 0, 0, 32'h0, 16'd8, 16'd4);

    // Wrong predicted target is a mispredict and retrains the target.
    drv(0, 1, 1, 32'h80, 32'h300, 1, 32'h200, 32'h80);
    ex("tgt_change", 1, 32'h200, 1, 1, 32'h300, 16'd8, 16'd4);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h80);
    ex("tgt_updated", 1, 32'h300, 0, 0, 32'h0, 16'd9, 16'd5);

    // Fall-through PC wraps at the top of the address space.
    drv(0, 1, 0, 32'hFFFF_FFFC, 32'h1234, 1, 32'h1234, 32'h80);
    ex("pc4_wrap", 1, 32'h300, 1, 1, 32'h0, 16'd9, 16'd5);

    // Reset together with a branch: no table write, everything cleared.
    drv(1, 1, 1, 32'h44, 32'h600, 0, 32'h0, 32'h80);
    ex("rst_with_branch", 0, 32'h0, 0, 1, 32'h0, 16'd10, 16'd6);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h80);
    ex("rst_cleared", 0, 32'h0, 0, 0, 32'h0, 16'd0, 16'd0);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h44);
    ex("rst_no_write", 0, 32'h0, 0, 0, 32'h0, 16'd0, 16'd0);

    // Branch counter saturation with correctly predicted not-taken misses.
    for (int i = 0; i < 65534; i++) drv(0, 1, 0, 32'hC0, 32'h0, 0, 32'h0, 32'h40);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h40);
    ex("cnt_below_sat", 0, 32'h0, 0, 0, 32'h0, 16'hFFFE, 16'd0);
    for (int i = 0; i < 3; i++) drv(0, 1, 0, 32'hC0, 32'h0, 0, 32'h0, 32'h40);
    drv(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h40);
    ex("cnt_saturated", 0, 32'h0, 0, 0, 32'h0, 16'hFFFF, 16'd0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    check("scoreboard_drain", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
